sub_serial: RTL and testbench



---
 rtl/sub_serial.sv | 89 ++++++++
 tb/tb_sub_serial.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// sub_serial: digit-serial subtractor computing inA - inB over WIDTH/DIGIT clocks with zero/borrow/overflow status
module sub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] subout,
  output logic             flag,
  output logic             borrow,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sub_q, sub_d, res_nx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, ma_q, ma_d, mb_q, mb_d;
  logic             flag_q, flag_d, borrow_q, borrow_d, ovf_q, ovf_d;
  logic [DIGIT:0]   dsum;
  logic             accept, run, last;
  // result digits enter from the MSB end so the word is assembled after N shifts
  if (DIGIT == WIDTH) begin : g_full
    assign res_nx = dsum[DIGIT-1:0];
  end else begin : g_part
    assign res_nx = {dsum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
  end
  // digit adder, control decode and next-state for every register
  always_comb begin
    dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, ~b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    accept   = start && state_q != RUN;
    run      = state_q == RUN;
    last     = run && cnt_q == CW'(N - 1);
    state_d  = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
    a_d      = accept ? inA : run ? a_q >> DIGIT : a_q;
    b_d      = accept ? inB : run ? b_q >> DIGIT : b_q;
    ma_d     = accept ? inA[WIDTH-1] : ma_q;
    mb_d     = accept ? inB[WIDTH-1] : mb_q;
    carry_d  = accept ? 1'b1 : run ? dsum[DIGIT] : carry_q;
    cnt_d    = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    res_d    = run ? res_nx : res_q;
    sub_d    = last ? res_nx : sub_q;
    flag_d   = last ? res_nx == '0 : flag_q;
    borrow_d = last ? ~dsum[DIGIT] : borrow_q;
    ovf_d    = last ? (ma_q != mb_q) && (res_nx[WIDTH-1] != ma_q) : ovf_q;
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sub_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ma_q     <= 1'b0;
      mb_q     <= 1'b0;
      flag_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      sub_q    <= sub_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      flag_q   <= flag_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign subout = sub_q;
  assign flag   = flag_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed scoreboard bench for sub_serial (DIGIT=1 and DIGIT=4 builds)
module tb_sub_serial;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start4 = 1'b0;
  logic [31:0] inA = '0, inB = '0, a4 = '0, b4 = '0;
  logic        busy, done, flag, borrow, ovf;
  logic        busy4, done4, flag4, borrow4, ovf4;
  logic [31:0] subout, subout4;
  typedef struct packed {logic [31:0] d; logic f; logic b; logic o;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  sub_serial #(.WIDTH(32), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB), .busy(busy), .done(done),
    .subout(subout), .flag(flag), .borrow(borrow), .ovf(ovf));
  sub_serial #(.WIDTH(32), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .inA(a4), .inB(b4), .busy(busy4), .done(done4),
    .subout(subout4), .flag(flag4), .borrow(borrow4), .ovf(ovf4));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return '{d: d, f: d == 0, b: a < b, o: (a[31] != b[31]) && (d[31] != a[31])};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    inA = a;
    inB = b;
    start = 1'b1;
    q.push_back(model(a, b));
    step();
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic finish_op(input string tag, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_queue"}, q.size(), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_subout"}, subout, e.d);
      chk({tag, "_flag"}, 32'(flag), 32'(e.f));
      chk({tag, "_borrow"}, 32'(borrow), 32'(e.b));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.o));
    end
  endtask

  initial begin
    int n, seen;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_subout", subout, 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step();
    a4 = 32'd100;
    b4 = 32'd58;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 100) begin
      step();
      n++;
    end
    chk("d4_latency", n, 8);
    chk("d4_subout", subout4, 32'd42);
    chk("d4_flag", 32'(flag4), 32'd0);
    chk("d4_borrow", 32'(borrow4), 32'd0);
    step();
    launch(32'd5, 32'd3);
    finish_op("5m3", 32);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    launch(32'd3, 32'd5);
    finish_op("3m5", 32);
    launch(32'h12345678, 32'h12345678);
    finish_op("b2b_equal", 32);
    step();
    launch(32'h80000000, 32'd1);
    repeat (9) step();
    inA = 32'hDEADBEEF;
    inB = 32'h00C0FFEE;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ignored_start_busy", 32'(busy), 32'd1);
    finish_op("minneg_m1", 22);
    step();
    launch(32'h7FFFFFFF, 32'hFFFFFFFF);
    finish_op("max_m_neg1", 32);
    step();
    launch(32'd1000, 32'd1);
    repeat (14) step();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_subout", subout, 32'd0);
    chk("midrst_flag", 32'(flag), 32'd0);
    chk("midrst_borrow", 32'(borrow), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    void'(q.pop_back());
    step();
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      step();
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    launch(32'd100, 32'd58);
    finish_op("after_rst", 32);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
